// File: rtl/wforward_arbiter_if.sv
// Bus bundle for wforward_arbiter: per-master AXI AW/W sources plus the shared forward link.
// The master modport is the source/link-sink side; the slave modport is the arbiter.
interface wforward_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  logic [77*NUM_MASTERS-1:0] S_AWDATA;
  logic [NUM_MASTERS-1:0]    S_AWVALID;
  logic [NUM_MASTERS-1:0]    S_AWREADY;
  logic [77*NUM_MASTERS-1:0] S_WDATA;
  logic [NUM_MASTERS-1:0]    S_WVALID;
  logic [NUM_MASTERS-1:0]    S_WREADY;
  logic [76:0]               DATA;
  logic                      VALID;
  logic                      READY;
  logic [NUM_MASTERS-1:0]    GRANT;
  logic                      LEN_ERR;

  modport master (
    output S_AWDATA, S_AWVALID, S_WDATA, S_WVALID, READY,
    input  S_AWREADY, S_WREADY, DATA, VALID, GRANT, LEN_ERR
  );

  modport slave (
    input  S_AWDATA, S_AWVALID, S_WDATA, S_WVALID, READY,
    output S_AWREADY, S_WREADY, DATA, VALID, GRANT, LEN_ERR
  );
endinterface

// File: rtl/wforward_arbiter.sv
// Round-robin arbiter that serialises AXI write bursts (command beat + W beats) from several
// masters onto one 77-bit registered forward link, with a one-cycle AWLEN/WLAST mismatch flag.
module wforward_arbiter #(
  parameter int unsigned NUM_MASTERS = 2
) (
  input logic               CLK,
  input logic               RESET,
  wforward_arbiter_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(NUM_MASTERS);
  localparam int unsigned CandW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]        owner_q, owner_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [76:0]            data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   len_err_q, len_err_d;

  logic [PtrW-1:0]  win;
  logic             win_found;
  logic [CandW-1:0] cand;
  logic [76:0]      aw_sel, w_sel;
  logic             slot_free, aw_hs, w_hs, w_last;

  assign slot_free = !valid_q || bus.READY;

  // First AW requester at or above rr_ptr, wrapping around.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      cand = {1'b0, rr_ptr_q} + CandW'(off);
      if (cand >= CandW'(NUM_MASTERS)) cand = cand - CandW'(NUM_MASTERS);
      if (!win_found && bus.S_AWVALID[cand[PtrW-1:0]]) begin
        win       = cand[PtrW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    aw_sel = '0;
    w_sel  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (win == PtrW'(i))     aw_sel = bus.S_AWDATA[77*i +: 77];
      if (owner_q == PtrW'(i)) w_sel  = bus.S_WDATA[77*i +: 77];
    end
  end

  assign w_last = w_sel[0];
  assign aw_hs  = (state_q == StIdle) && win_found && slot_free;
  assign w_hs   = (state_q == StBurst) && slot_free && bus.S_WVALID[owner_q];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (aw_hs) state_d = StBurst;
      StBurst: if (w_hs && w_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Source readies: only the winner (idle) or the owner (burst), and only when the slot frees.
  always_comb begin
    bus.S_AWREADY = '0;
    bus.S_WREADY  = '0;
    unique case (state_q)
      StIdle:  if (win_found) bus.S_AWREADY[win] = slot_free;
      StBurst: bus.S_WREADY[owner_q] = slot_free;
      default: ;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    len_err_d  = 1'b0;
    if (aw_hs) begin
      data_d     = aw_sel;
      valid_d    = 1'b1;
      owner_d    = win;
      beat_cnt_d = aw_sel[32:25];
      grant_d    = NUM_MASTERS'(1) << win;
      rr_ptr_d   = (win == PtrW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
    end else if (w_hs) begin
      data_d    = w_sel;
      valid_d   = 1'b1;
      len_err_d = w_last ? (beat_cnt_q != 8'd0) : (beat_cnt_q == 8'd0);
      if (w_last) begin
        grant_d = '0;
      end else if (beat_cnt_q != 8'd0) begin
        beat_cnt_d = beat_cnt_q - 8'd1;
      end
    end else if (bus.READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      len_err_q  <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      len_err_q  <= len_err_d;
    end
  end

  assign bus.DATA    = data_q;
  assign bus.VALID   = valid_q;
  assign bus.GRANT   = grant_q;
  assign bus.LEN_ERR = len_err_q;

endmodule

// File: tb/tb_wforward_arbiter.sv
// Bench for wforward_arbiter: random burst contents, a queue-based link model with round-robin
// ordering, and directed scenarios for contention, back-pressure, length errors and reset.
module tb_wforward_arbiter;
  localparam int unsigned NM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wforward_arbiter_if #(.NUM_MASTERS(NM)) bus ();
  wforward_arbiter #(.NUM_MASTERS(NM)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  logic [76:0] aw_data [NM];
  logic [76:0] w_data  [NM];
  logic        aw_valid[NM];
  logic        w_valid [NM];
  logic        ready;
  int          ready_mode;

  assign bus.S_AWDATA  = {aw_data[1], aw_data[0]};
  assign bus.S_WDATA   = {w_data[1], w_data[0]};
  assign bus.S_AWVALID = {aw_valid[1], aw_valid[0]};
  assign bus.S_WVALID  = {w_valid[1], w_valid[0]};
  assign bus.READY     = ready;

  int checks = 0;
  int passed = 0;

  // Scenario: per-master list of bursts, and the expected link stream derived from it.
  logic [76:0] b_aw[NM][4];
  int          b_nw[NM][4];
  logic [76:0] b_w [NM][4][16];
  int          nb  [NM];
  logic [76:0] exp_q[$];
  int          exp_lerr;
  int          lerr_cnt;
  bit          mon_en;
  bit          cont;
  bit          started;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_scn();
    for (int m = 0; m < NM; m++) nb[m] = 0;
  endtask

  task automatic add_burst(input int m, input int awlen, input int nw, input logic [7:0] awid);
    logic [76:0] a;
    logic [76:0] w;
    a = 77'({$urandom(), $urandom(), $urandom()});
    a[76:69] = awid;
    a[32:25] = 8'(awlen);
    b_aw[m][nb[m]] = a;
    b_nw[m][nb[m]] = nw;
    for (int k = 0; k < nw; k++) begin
      w = 77'({$urandom(), $urandom(), $urandom()});
      w[0] = (k == nw - 1);
      b_w[m][nb[m]][k] = w;
    end
    nb[m]++;
  endtask

  // Every master keeps its next AW pending, so the link order is plain round-robin over
  // the masters that still have bursts left, starting from master 0 after reset.
  task automatic build_model();
    int ptr;
    int left;
    int idx[NM];
    ptr = 0;
    left = 0;
    exp_q.delete();
    exp_lerr = 0;
    for (int m = 0; m < NM; m++) begin
      idx[m] = 0;
      left += nb[m];
    end
    while (left > 0) begin
      int c;
      int len;
      c = -1;
      for (int k = 0; k < NM; k++) begin
        int t;
        t = (ptr + k) % NM;
        if (c < 0 && idx[t] < nb[t]) c = t;
      end
      exp_q.push_back(b_aw[c][idx[c]]);
      len = int'(b_aw[c][idx[c]][32:25]);
      for (int k = 0; k < b_nw[c][idx[c]]; k++) begin
        bit last;
        last = (k == b_nw[c][idx[c]] - 1);
        exp_q.push_back(b_w[c][idx[c]][k]);
        if ((last && len > k) || (!last && k >= len)) exp_lerr++;
      end
      idx[c]++;
      ptr = (c + 1) % NM;
      left--;
    end
  endtask

  task automatic wait_hs(input int m, input bit is_aw, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (is_aw ? bus.S_AWREADY[m] : bus.S_WREADY[m]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    chk("handshake", ok, 1'b1);
  endtask

  task automatic send_burst(input int m, input int j, input bit early_w);
    bit ok;
    aw_data[m]  = b_aw[m][j];
    aw_valid[m] = 1'b1;
    if (early_w) begin
      w_data[m]  = b_w[m][j][0];
      w_valid[m] = 1'b1;
    end
    wait_hs(m, 1'b1, ok);
    aw_valid[m] = 1'b0;
    if (!ok) return;
    chk("cmd_latency", bus.DATA, b_aw[m][j]);
    chk("grant_onehot", bus.GRANT, 80'(1) << m);
    for (int k = 0; k < b_nw[m][j]; k++) begin
      w_data[m]  = b_w[m][j][k];
      w_valid[m] = 1'b1;
      wait_hs(m, 1'b0, ok);
      if (!ok) begin
        w_valid[m] = 1'b0;
        return;
      end
      chk("w_latency", bus.DATA, b_w[m][j][k]);
    end
    w_valid[m] = 1'b0;
    chk("grant_released", bus.GRANT, 80'(0));
  endtask

  task automatic drive_master(input int m, input int delay, input bit early_w);
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1;
    end
    for (int j = 0; j < nb[m]; j++) send_burst(m, j, early_w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int m = 0; m < NM; m++) begin
      aw_valid[m] = 1'b0;
      w_valid[m]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    lerr_cnt = 0;
    started  = 1'b0;
  endtask

  task automatic run_scn(input int delay1, input bit early1, input bit cont_mode);
    do_reset();
    build_model();
    cont   = cont_mode;
    mon_en = 1'b1;
    fork
      drive_master(0, 0, 1'b0);
      drive_master(1, delay1, early1);
    join
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_drained", exp_q.size(), 80'(0));
    chk("len_err_count", lerr_cnt, exp_lerr);
    cont   = 1'b0;
    mon_en = 1'b0;
  endtask

  initial begin
    int phase;
    phase = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ready = (phase % 4 == 0) || (phase % 4 == 3);
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      phase++;
    end
  end

  // Link monitor: sampled on the falling edge, where every input is settled for the next rise.
  initial begin
    bit          hold_v;
    logic [76:0] hold_d;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (bus.GRANT != '0) chk("aw_ready_in_burst", bus.S_AWREADY, 80'(0));
        chk("w_ready_owner_only", bus.S_WREADY & ~bus.GRANT, 80'(0));
        if (bus.VALID && !bus.READY) chk("stall_readies", {bus.S_AWREADY, bus.S_WREADY}, 80'(0));
        if (hold_v) chk("data_hold", bus.DATA, hold_d);
        hold_v = bus.VALID && !bus.READY;
        hold_d = bus.DATA;
        if (bus.LEN_ERR) lerr_cnt++;
        if (mon_en && cont && started && exp_q.size() != 0) chk("no_bubble", bus.VALID, 1'b1);
        if (mon_en && bus.VALID && bus.READY) begin
          started = 1'b1;
          chk("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) chk("link_beat", bus.DATA, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    logic [76:0] aw1;
    ready_mode = 0;
    mon_en     = 1'b0;
    cont       = 1'b0;
    started    = 1'b0;
    lerr_cnt   = 0;
    for (int m = 0; m < NM; m++) begin
      aw_data[m] = '0;
      w_data[m]  = '0;
    end
    do_reset();
    chk("reset_valid", bus.VALID, 1'b0);
    chk("reset_data", bus.DATA, 80'(0));
    chk("reset_grant", bus.GRANT, 80'(0));
    chk("reset_len_err", bus.LEN_ERR, 1'b0);
    chk("reset_awready", bus.S_AWREADY, 80'(0));
    chk("reset_wready", bus.S_WREADY, 80'(0));

    // Single 4-beat burst, back-to-back on the link.
    clear_scn();
    add_burst(0, 3, 4, 8'h11);
    run_scn(0, 1'b0, 1'b1);

    // Simultaneous requests, three bursts each: 0,1,0,1,0,1 with no idle link cycles.
    clear_scn();
    for (int j = 0; j < 3; j++) begin
      add_burst(0, 0, 1, 8'h20);
      add_burst(1, 0, 1, 8'h21);
    end
    run_scn(0, 1'b0, 1'b1);

    // Master 1 asks (AW and W) in the middle of master 0's 8-beat burst.
    clear_scn();
    add_burst(0, 7, 8, 8'h40);
    add_burst(1, 1, 2, 8'h41);
    run_scn(3, 1'b1, 1'b1);

    // Back-pressure 1,0,0,1 during a 7-beat transfer.
    ready_mode = 1;
    clear_scn();
    add_burst(0, 5, 6, 8'h50);
    run_scn(0, 1'b0, 1'b0);
    ready_mode = 0;

    // Early WLAST, then late WLAST.
    clear_scn();
    add_burst(0, 3, 2, 8'h60);
    run_scn(0, 1'b0, 1'b1);
    clear_scn();
    add_burst(0, 1, 3, 8'h61);
    run_scn(0, 1'b0, 1'b1);

    // Reset in the middle of a burst while the slot holds a beat.
    clear_scn();
    add_burst(0, 7, 8, 8'h70);
    do_reset();
    aw_data[0]  = b_aw[0][0];
    aw_valid[0] = 1'b1;
    w_data[0]   = b_w[0][0][0];
    w_valid[0]  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("valid_before_reset", bus.VALID, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_after_reset", bus.VALID, 1'b0);
    chk("grant_after_reset", bus.GRANT, 80'(0));
    aw_valid[0] = 1'b0;
    w_valid[0]  = 1'b0;
    aw1 = 77'({$urandom(), $urandom(), $urandom()});
    aw1[32:25]  = 8'd0;
    aw_data[1]  = aw1;
    aw_valid[1] = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    aw_valid[1] = 1'b0;
    chk("m1_grant_after_reset", bus.GRANT, 80'(2));
    chk("m1_cmd_after_reset", bus.DATA, aw1);

    // Random burst shapes and lengths under random back-pressure.
    ready_mode = 2;
    clear_scn();
    for (int j = 0; j < 3; j++) begin
      for (int m = 0; m < NM; m++) begin
        int awlen;
        int nw;
        awlen = int'($urandom_range(0, 6));
        nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : awlen + 1;
        add_burst(m, awlen, nw, 8'($urandom()));
      end
    end
    run_scn(0, 1'b0, 1'b0);
    ready_mode = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
